o_buf_arbiter: RTL and testbench
================================

Name: o_buf_arbiter

Overview:
- Time-multiplexes one output pad between NUM_REQ requesters.
- Sits in front of an output buffer and its tristate enable; drives the buffer's data input (O) and output enable (OE).
- Round-robin request/grant arbitration with a bounded hold time per grant.
- Enforces turnaround cycles with OE low between owners, so two drivers never contend on the pad.

Parameters:
- NUM_REQ, 4, number of requesters; legal 2..16.
- MAX_HOLD, 16, maximum beats per grant; legal 1..256.
- TURNAROUND, 1, idle cycles with OE=0 between grants; legal 0..15.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, asynchronous, active-low.
- REQ  input  NUM_REQ  per-requester request, level.
- DATA  input  NUM_REQ  per-requester data bit.
- LAST  input  NUM_REQ  per-requester end-of-burst marker; qualified by a beat.
- GNT  output  NUM_REQ  one-hot grant, registered.
- O  output  1  pad data; connects to output buffer I.
- OE  output  1  pad output enable.
- BUSY  output  1  high in GRANT or TURN.

Behaviour:
- Reset (RST=0, async): GNT=0, O=0, OE=0, BUSY=0, state=IDLE, hold counter=0, turnaround counter=0, pointer=NUM_REQ-1 (so REQ[0] has first priority).
- Beat definition: a beat is GNT[i]&REQ[i] at a rising edge.
- Beat action: on a beat, O<=DATA[i] and OE<=1. O therefore lags DATA by 1 cycle.
- IDLE state:
  - If any REQ is high, select the first set bit searching from pointer+1 upward, wrapping mod NUM_REQ.
  - Set GNT one-hot and pointer<=winner, then go to GRANT.
  - Latency: REQ high at edge n gives GNT high after edge n.
- GRANT state, owner i, at each edge:
  - REQ[i]=0: not a beat; grant ends.
  - Beat with LAST[i]=1: grant ends.
  - Beat where the hold counter reaches MAX_HOLD: grant ends.
  - Otherwise: hold counter increments and the grant continues.
- Grant end:
  - GNT<=0 and hold counter<=0.
  - If TURNAROUND>0, go to TURN with OE<=0.
  - If TURNAROUND=0, arbitrate in the same edge: GNT moves directly to the next winner with no gap. If no request is pending, go to IDLE with OE<=0.
- TURN state:
  - Count TURNAROUND edges with OE=0 and O holding its last value; GNT stays 0.
  - Then go to IDLE. Requests are sampled only in IDLE, so there is no extra bubble beyond TURNAROUND+1 cycles.
- Fairness: the pointer updates only on a win. With all requesters active, grants rotate 0,1,2,3,0,...
- Requester dropping REQ mid-grant: treated as an abort. OE falls on the following edge, which is the same as normal termination.
- Simultaneous LAST and hold-limit on one beat: a single termination, no double count.
- Undefined inputs: REQ/DATA/LAST of non-owners are ignored. An X on REQ[owner] is not required to be handled.
- Reset mid-grant: all outputs clear asynchronously and OE falls immediately; no turnaround is enforced after reset release.
- Parameter checks at elaboration/initial time, in the primitive check style:
  - An out-of-range NUM_REQ, MAX_HOLD or TURNAROUND triggers $display("Error: o_buf_arbiter instance %m ...") listing the legal range.
  - This is followed by #1 $stop.

Decomposition:
- Shared header/package o_buf_arb_pkg:
  - State encodings IDLE=2'd0, GRANT=2'd1, TURN=2'd2.
  - Width constants: pointer width = clog2(NUM_REQ), hold width = clog2(MAX_HOLD+1), turnaround width = 4.
- One sub-module, rr_pick: combinational round-robin search.
  - Inputs: REQ vector and pointer.
  - Outputs: one-hot winner and its index.
- The FSM, counters and output registers stay in o_buf_arbiter.

Test Plan:
- Reset and single request: RST low with REQ=4'b0100 → GNT=0, OE=0. After release: GNT=4'b0100 one cycle after REQ is sampled; OE=1 and O=DATA[2] on the following cycle.
- LAST termination: requester 1 sends DATA 1,0,1 with LAST on the 3rd beat, TURNAROUND=1 → O sequence 1,0,1; then OE=0 for exactly 2 cycles (turn + idle) before the next grant.
- Round-robin: REQ=4'b1111 held, every burst LAST on its 1st beat → grant order 0,1,2,3,0, each grant 1 beat; no requester starved.
- Hold limit: MAX_HOLD=4, REQ[3] held with LAST=0 and REQ[0] pending → GNT[3] for exactly 4 beats, turnaround, then GNT[0].
- Abort and TURNAROUND=0: owner 2 drops REQ after 2 beats with REQ[3] pending → GNT moves 2→3 on one edge; OE stays 1; O shows DATA[3] one cycle later.
- Async reset mid-grant: assert RST between edges during GRANT → GNT, OE, O and BUSY go to 0 without waiting for CLK. After release, REQ=4'b0011 → GNT[0] first.

Source files
------------

// File: rtl/o_buf_arb_pkg.sv
// rtl/o_buf_arb_pkg.sv - shared state encodings and width helpers for the output-pad arbiter
package o_buf_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  localparam int TURN_W = 4;

  function automatic int ptr_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int hold_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/o_buf_arbiter_rr_pick.sv
// rtl/o_buf_arbiter_rr_pick.sv - combinational round-robin search starting just above the pointer
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_win,
  output logic [PTR_W-1:0]   o_win_idx,
  output logic               o_valid
);

  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  // The pointer itself is visited last, so the previous winner has lowest priority.
  always_comb begin
    o_win     = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_win[w_cand] = 1'b1;
        o_win_idx     = w_cand;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/o_buf_arbiter.sv
// rtl/o_buf_arbiter.sv - round-robin owner of one output pad with bounded hold and OE turnaround
module o_buf_arbiter
  import o_buf_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] DATA,
  input  logic [NUM_REQ-1:0] LAST,
  output logic [NUM_REQ-1:0] GNT,
  output logic               O,
  output logic               OE,
  output logic               BUSY
);

  localparam int PTR_W  = ptr_w(NUM_REQ);
  localparam int HOLD_W = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
  localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("Error: o_buf_arbiter instance %m NUM_REQ=%0d outside legal range 2..16", NUM_REQ);
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("Error: o_buf_arbiter instance %m MAX_HOLD=%0d outside legal range 1..256", MAX_HOLD);
  end
  if (TURNAROUND < 0 || TURNAROUND > 15) begin : g_bad_turnaround
    $error("Error: o_buf_arbiter instance %m TURNAROUND=%0d outside legal range 0..15", TURNAROUND);
  end

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_o;
  logic               r_oe;
  logic [PTR_W-1:0]   r_ptr;
  logic [HOLD_W-1:0]  r_hold;
  logic [TURN_W-1:0]  r_turn;

  logic [NUM_REQ-1:0] w_win;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_valid;
  logic               w_beat;
  logic               w_last;
  logic               w_data;
  logic               w_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req     (REQ),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx),
    .o_valid   (w_valid)
  );

  // GNT is one-hot, so masking with it ignores every non-owner input.
  assign w_beat = |(r_gnt & REQ);
  assign w_last = |(r_gnt & LAST);
  assign w_data = |(r_gnt & DATA);
  assign w_end  = !w_beat || w_last || (r_hold == HOLD_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_o     <= 1'b0;
      r_oe    <= 1'b0;
      r_ptr   <= PTR_INIT;
      r_hold  <= '0;
      r_turn  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_oe <= 1'b0;
          if (w_valid) begin
            r_gnt   <= w_win;
            r_ptr   <= w_win_idx;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_beat) begin
            r_o  <= w_data;
            r_oe <= 1'b1;
          end
          if (!w_end) begin
            r_hold <= r_hold + 1'b1;
          end else begin
            r_hold <= '0;
            r_gnt  <= '0;
            if (TURNAROUND > 0) begin
              r_state <= ST_TURN;
              r_turn  <= '0;
              if (!w_beat) r_oe <= 1'b0;
            end else if (w_valid) begin
              // Zero turnaround: hand the pad over on this edge, OE untouched.
              r_gnt <= w_win;
              r_ptr <= w_win_idx;
            end else begin
              r_state <= ST_IDLE;
              if (!w_beat) r_oe <= 1'b0;
            end
          end
        end
        ST_TURN: begin
          r_oe <= 1'b0;
          if (r_turn == TURN_LAST) begin
            r_turn  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_turn <= r_turn + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign GNT  = r_gnt;
  assign O    = r_o;
  assign OE   = r_oe;
  assign BUSY = (r_state == ST_GRANT) || (r_state == ST_TURN);

endmodule

// File: tb/tb_o_buf_arbiter.sv
// tb/tb_o_buf_arbiter.sv - directed bench for o_buf_arbiter with turnaround and zero-turnaround instances
module tb_o_buf_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, data_a, last_a, gnt_a;
  logic [3:0] req_b, data_b, last_b, gnt_b;
  logic       o_a, oe_a, busy_a;
  logic       o_b, oe_b, busy_b;

  int total;
  int bad;

  o_buf_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .TURNAROUND(1)) dut_a (
    .CLK(clk), .RST(rst_n), .REQ(req_a), .DATA(data_a), .LAST(last_a),
    .GNT(gnt_a), .O(o_a), .OE(oe_a), .BUSY(busy_a)
  );

  o_buf_arbiter #(.NUM_REQ(4), .MAX_HOLD(16), .TURNAROUND(0)) dut_b (
    .CLK(clk), .RST(rst_n), .REQ(req_b), .DATA(data_b), .LAST(last_b),
    .GNT(gnt_b), .O(o_b), .OE(oe_b), .BUSY(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] rr_data;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    req_a  = 4'b0100; data_a = 4'b0100; last_a = 4'b0000;
    req_b  = 4'b0000; data_b = 4'b0000; last_b = 4'b0000;
    tick();
    tick();
    chk("rst_gnt", gnt_a, 4'b0000);
    chk("rst_oe", oe_a, 1'b0);
    chk("rst_o", o_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_gnt_b", gnt_b, 4'b0000);

    // single request from requester 2
    rst_n = 1'b1;
    tick();
    chk("single_gnt", gnt_a, 4'b0100);
    chk("single_busy", busy_a, 1'b1);
    chk("single_oe_pre", oe_a, 1'b0);
    tick();
    chk("single_oe", oe_a, 1'b1);
    chk("single_o", o_a, 1'b1);
    last_a = 4'b0100;
    tick();
    chk("single_end_gnt", gnt_a, 4'b0000);
    chk("single_end_oe", oe_a, 1'b1);
    req_a = 4'b0000; last_a = 4'b0000;
    tick();
    chk("single_turn_oe", oe_a, 1'b0);
    chk("single_idle_busy", busy_a, 1'b0);

    // LAST termination: requester 1 sends 1,0,1
    req_a = 4'b0010; data_a = 4'b0010;
    tick();
    chk("last_gnt", gnt_a, 4'b0010);
    tick();
    chk("last_o1", o_a, 1'b1);
    chk("last_oe1", oe_a, 1'b1);
    data_a = 4'b0000;
    tick();
    chk("last_o2", o_a, 1'b0);
    chk("last_oe2", oe_a, 1'b1);
    data_a = 4'b0010; last_a = 4'b0010;
    tick();
    chk("last_o3", o_a, 1'b1);
    chk("last_oe3", oe_a, 1'b1);
    chk("last_gnt_drop", gnt_a, 4'b0000);
    data_a = 4'b0000; last_a = 4'b0000;
    tick();
    chk("last_gap1_oe", oe_a, 1'b0);
    chk("last_gap1_gnt", gnt_a, 4'b0000);
    tick();
    chk("last_gap2_oe", oe_a, 1'b0);
    chk("last_regrant", gnt_a, 4'b0010);
    tick();
    chk("last_regrant_oe", oe_a, 1'b1);
    req_a = 4'b0000;
    tick();
    tick();
    tick();
    chk("last_settle_busy", busy_a, 1'b0);

    // round robin with every requester active and 1-beat bursts
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    rr_data = 4'b1010;
    req_a = 4'b1111; last_a = 4'b1111; data_a = rr_data;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_gnt%0d", k), gnt_a, 4'b0001 << (k % 4));
      tick();
      chk($sformatf("rr_o%0d", k), o_a, rr_data[k % 4]);
      chk($sformatf("rr_oe%0d", k), oe_a, 1'b1);
      tick();
    end
    req_a = 4'b0000; last_a = 4'b0000; data_a = 4'b0000;
    tick();

    // hold limit: requester 3 streams without LAST, requester 0 waits
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_a = 4'b1000; data_a = 4'b1000;
    tick();
    chk("hold_gnt", gnt_a, 4'b1000);
    req_a = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold_beat%0d_gnt", i), gnt_a, (i < 3) ? 4'b1000 : 4'b0000);
      chk($sformatf("hold_beat%0d_oe", i), oe_a, 1'b1);
    end
    tick();
    chk("hold_turn_oe", oe_a, 1'b0);
    chk("hold_turn_gnt", gnt_a, 4'b0000);
    tick();
    chk("hold_next_gnt", gnt_a, 4'b0001);
    req_a = 4'b0000;
    tick();
    tick();

    // abort with zero turnaround: owner 2 drops after 2 beats, 3 pending
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_b = 4'b0100; data_b = 4'b0100;
    tick();
    chk("abort_gnt2", gnt_b, 4'b0100);
    req_b = 4'b1100;
    tick();
    chk("abort_beat1_o", o_b, 1'b1);
    chk("abort_beat1_gnt", gnt_b, 4'b0100);
    data_b = 4'b0000;
    tick();
    chk("abort_beat2_o", o_b, 1'b0);
    chk("abort_beat2_oe", oe_b, 1'b1);
    req_b = 4'b1000; data_b = 4'b1000;
    tick();
    chk("abort_handover_gnt", gnt_b, 4'b1000);
    chk("abort_handover_oe", oe_b, 1'b1);
    chk("abort_handover_o", o_b, 1'b0);
    tick();
    chk("abort_new_o", o_b, 1'b1);
    chk("abort_new_oe", oe_b, 1'b1);
    req_b = 4'b0000;
    tick();
    chk("abort_idle_oe", oe_b, 1'b0);
    chk("abort_idle_busy", busy_b, 1'b0);

    // asynchronous reset in the middle of a grant
    req_b = 4'b0100; data_b = 4'b0100;
    tick();
    tick();
    chk("arst_pre_oe", oe_b, 1'b1);
    chk("arst_pre_gnt", gnt_b, 4'b0100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt_b, 4'b0000);
    chk("arst_oe", oe_b, 1'b0);
    chk("arst_o", o_b, 1'b0);
    chk("arst_busy", busy_b, 1'b0);
    tick();
    req_b = 4'b0011; data_b = 4'b0000;
    rst_n = 1'b1;
    tick();
    chk("arst_first_gnt", gnt_b, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
